// File: rtl/genius_seq_ctrl.sv
// Genius (Simon) game sequencer: plays back a growing colour sequence and checks the player's presses.
// Optional macro GENIUS_TIMEOUT_EN adds a LOSE-on-inactivity timer in WAIT_IN (T_TIMEOUT idle cycles).
module genius_seq_ctrl #(
  parameter int T_ON      = 50,
  parameter int T_OFF     = 25,
  parameter int T_TIMEOUT = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] botoes,
  input  logic [3:0] seq_saida,
  output logic [3:0] address,
  output logic [3:0] leds,
  output logic [3:0] nivel,
  output logic       vitoria,
  output logic       derrota
);

  typedef enum logic [2:0] {IDLE, GAP, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE} state_t;

  localparam int TMAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int CW   = $clog2(TMAX + 1);

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    nivel_q, nivel_d;
  logic [CW-1:0] timer_q, timer_d;

`ifdef GENIUS_TIMEOUT_EN
  localparam int TW = $clog2(T_TIMEOUT + 1);
  logic [TW-1:0] idle_q, idle_d;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      nivel_q <= '0;
      timer_q <= '0;
`ifdef GENIUS_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nivel_q <= nivel_d;
      timer_q <= timer_d;
`ifdef GENIUS_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  // The phase timer clears by default so every timed state starts counting from zero.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nivel_d = nivel_q;
    timer_d = '0;
`ifdef GENIUS_TIMEOUT_EN
    idle_d  = idle_q;
`endif
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          nivel_d = '0;
          idx_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (timer_q == CW'(T_OFF - 1)) begin
          idx_d   = '0;
          state_d = SHOW_ON;
        end else begin
          timer_d = timer_q + CW'(1);
        end
      end
      SHOW_ON: begin
        if (timer_q == CW'(T_ON - 1)) state_d = SHOW_OFF;
        else                          timer_d = timer_q + CW'(1);
      end
      SHOW_OFF: begin
        if (timer_q == CW'(T_OFF - 1)) begin
          if (idx_q == nivel_q) begin
            idx_d   = '0;
            state_d = WAIT_IN;
`ifdef GENIUS_TIMEOUT_EN
            idle_d  = '0;
`endif
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SHOW_ON;
          end
        end else begin
          timer_d = timer_q + CW'(1);
        end
      end
      WAIT_IN: begin
        // A press in the timeout cycle is evaluated first, so the player still gets that press.
        if (botoes != 4'b0000) begin
          if (botoes == seq_saida) begin
`ifdef GENIUS_TIMEOUT_EN
            idle_d = '0;
`endif
            if (idx_q < nivel_q) begin
              idx_d = idx_q + 4'd1;
            end else if (nivel_q != 4'd15) begin
              nivel_d = nivel_q + 4'd1;
              idx_d   = '0;
              state_d = GAP;
            end else begin
              state_d = WIN;
            end
          end else begin
            state_d = LOSE;
          end
        end
`ifdef GENIUS_TIMEOUT_EN
        else if (idle_q == TW'(T_TIMEOUT - 1)) begin
          state_d = LOSE;
        end else begin
          idle_d = idle_q + TW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign address = idx_q;
  assign nivel   = nivel_q;
  assign leds    = (state_q == SHOW_ON) ? seq_saida : 4'b0000;
  assign vitoria = (state_q == WIN);
  assign derrota = (state_q == LOSE);

endmodule

// File: tb/tb_genius_seq_ctrl.sv
// Directed plus randomized bench for genius_seq_ctrl; expected playback and responses come from the colour table.
// Build with GENIUS_TIMEOUT_EN defined to exercise the inactivity timeout instead of the indefinite wait.
module tb_genius_seq_ctrl;
  localparam int T_ON      = 4;
  localparam int T_OFF     = 2;
  localparam int T_TIMEOUT = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] botoes;
  logic [3:0] seq_saida;
  logic [3:0] address;
  logic [3:0] leds;
  logic [3:0] nivel;
  logic       vitoria;
  logic       derrota;

  logic [3:0] colorMem [16];
  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  assign seq_saida = colorMem[address];

  genius_seq_ctrl #(.T_ON(T_ON), .T_OFF(T_OFF), .T_TIMEOUT(T_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start), .botoes(botoes), .seq_saida(seq_saida),
    .address(address), .leds(leds), .nivel(nivel), .vitoria(vitoria), .derrota(derrota)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] b);
    start  = s;
    botoes = b;
    tick();
    start  = 1'b0;
    botoes = 4'b0000;
  endtask

  // Expected round n: dark gap, then colours 0..n each lit T_ON and dark T_OFF, then waiting for input.
  task automatic checkRound(input int n, input bit startInShow);
    for (int i = 0; i < T_OFF; i++) begin
      checkOutput("gap_leds", leds, 0);
      tick();
    end
    for (int k = 0; k <= n; k++) begin
      for (int j = 0; j < T_ON; j++) begin
        if (startInShow && k == 0 && j == 1) start = 1'b1;
        checkOutput("show_leds", leds, colorMem[k]);
        checkOutput("show_addr", address, k);
        tick();
        start = 1'b0;
      end
      for (int j = 0; j < T_OFF; j++) begin
        checkOutput("dark_leds", leds, 0);
        tick();
      end
    end
    checkOutput("wait_leds", leds, 0);
    checkOutput("wait_nivel", nivel, n);
    checkOutput("wait_addr", address, 0);
    checkOutput("wait_derrota", derrota, 0);
    checkOutput("wait_vitoria", vitoria, 0);
  endtask

  function automatic logic [3:0] randomWrong(input logic [3:0] correct);
    logic [3:0] v;
    v = 4'($urandom_range(1, 15));
    if (v == correct) v = ~correct;
    return v;
  endfunction

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    botoes = 4'b0000;
    colorMem[0] = 4'b0001;
    colorMem[1] = 4'b1000;
    colorMem[2] = 4'b0100;
    for (int i = 3; i < 16; i++) colorMem[i] = 4'b0001 << $urandom_range(0, 3);

    #2 reset = 1'b0;
    #1;
    checkOutput("rst_leds", leds, 0);
    checkOutput("rst_addr", address, 0);
    checkOutput("rst_nivel", nivel, 0);
    checkOutput("rst_vitoria", vitoria, 0);
    checkOutput("rst_derrota", derrota, 0);
    tick();
    tick();
    reset = 1'b1;
    checkOutput("rst_hold_leds", leds, 0);

    $display("[TB] first game: round 0, correct press, then multi-hot press");
    applyStimulus(1'b1, 4'b0000);
    checkRound(0, 1'b0);
    applyStimulus(1'b0, colorMem[0]);
    checkRound(1, 1'b0);
    applyStimulus(1'b0, colorMem[0]);
    checkOutput("idx_advance", address, 1);
    checkOutput("idx_advance_nivel", nivel, 1);
    applyStimulus(1'b0, 4'b1001);
    checkOutput("multihot_derrota", derrota, 1);
    checkOutput("lose_nivel", nivel, 1);
    checkOutput("lose_addr", address, 1);
    checkOutput("lose_leds", leds, 0);
    tick();
    checkOutput("lose_hold", derrota, 1);

    $display("[TB] restart from LOSE, wrong press at nivel 0");
    applyStimulus(1'b1, 4'b0000);
    checkOutput("restart_derrota", derrota, 0);
    checkOutput("restart_nivel", nivel, 0);
    checkRound(0, 1'b0);
    applyStimulus(1'b0, 4'b0100);
    checkOutput("wrong_derrota", derrota, 1);
    checkOutput("wrong_nivel", nivel, 0);

    $display("[TB] random wrong press at idx 1");
    applyStimulus(1'b1, 4'b0000);
    checkRound(0, 1'b0);
    applyStimulus(1'b0, colorMem[0]);
    checkRound(1, 1'b0);
    applyStimulus(1'b0, colorMem[0]);
    applyStimulus(1'b0, randomWrong(colorMem[1]));
    checkOutput("rndwrong_derrota", derrota, 1);

    $display("[TB] full game to WIN with ignored start pulses");
    applyStimulus(1'b1, 4'b0000);
    for (int n = 0; n < 16; n++) begin
      checkRound(n, n == 2);
      for (int k = 0; k <= n; k++) begin
        if (n == 3 && k == 1) begin
          applyStimulus(1'b1, 4'b0000);
          checkOutput("wait_start_leds", leds, 0);
          checkOutput("wait_start_nivel", nivel, 3);
          checkOutput("wait_start_addr", address, 1);
          checkOutput("wait_start_derrota", derrota, 0);
        end
        applyStimulus(1'b0, colorMem[k]);
        if (k < n) begin
          checkOutput("press_addr", address, k + 1);
          checkOutput("press_nivel", nivel, n);
        end
      end
    end
    checkOutput("win_vitoria", vitoria, 1);
    checkOutput("win_nivel", nivel, 15);
    checkOutput("win_addr", address, 15);
    checkOutput("win_leds", leds, 0);
    checkOutput("win_derrota", derrota, 0);
    tick();
    tick();
    tick();
    checkOutput("win_hold", vitoria, 1);
    checkOutput("win_hold_nivel", nivel, 15);

    $display("[TB] restart from WIN, idle in WAIT_IN");
    applyStimulus(1'b1, 4'b0000);
    checkOutput("restart_vitoria", vitoria, 0);
    checkRound(0, 1'b0);
`ifdef GENIUS_TIMEOUT_EN
    for (int i = 1; i <= T_TIMEOUT; i++) begin
      tick();
      checkOutput("timeout_derrota", derrota, (i == T_TIMEOUT) ? 1 : 0);
    end
    applyStimulus(1'b1, 4'b0000);
    checkRound(0, 1'b0);
`else
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (i % 250 == 249) checkOutput("nowait_derrota", derrota, 0);
    end
    checkOutput("nowait_leds", leds, 0);
    checkOutput("nowait_nivel", nivel, 0);
`endif

    $display("[TB] asynchronous reset in the middle of SHOW_ON");
    applyStimulus(1'b0, colorMem[0]);
    repeat (T_OFF + T_ON + T_OFF) tick();
    checkOutput("pre_rst_leds", leds, colorMem[1]);
    checkOutput("pre_rst_addr", address, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_rst_leds", leds, 0);
    checkOutput("async_rst_addr", address, 0);
    checkOutput("async_rst_nivel", nivel, 0);
    tick();
    reset = 1'b1;
    applyStimulus(1'b1, 4'b0000);
    checkRound(0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
